// File: rtl/fp_pkg.sv
// Shared definitions for the FP normalizer: FSM states and shift-select encodings.
// The optional sticky right shift is enabled by defining FP_NORM_STICKY_EN.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

    localparam logic [1:0] SEL_NONE  = 2'd0;
    localparam logic [1:0] SEL_RIGHT = 2'd1;
    localparam logic [1:0] SEL_LEFT  = 2'd2;

endpackage

// File: rtl/fp_shift_step.sv
// Combinational 1-bit mantissa shifter: hold, logical right, or logical left.
// With FP_NORM_STICKY_EN defined, a right shift ORs the dropped LSB into the new LSB.
module fp_shift_step
    import fp_pkg::*;
#(
    parameter int MANT_W = 29
) (
    input  logic [1:0]        sel_i,
    input  logic [MANT_W-1:0] mant_i,
    output logic [MANT_W-1:0] mant_o
);

    always_comb begin
        mant_o = mant_i;
        case (sel_i)
            SEL_RIGHT: begin
                mant_o = {1'b0, mant_i[MANT_W-1:1]};
`ifdef FP_NORM_STICKY_EN
                // Keep the lost bit visible to the rounder as a sticky bit.
                mant_o[0] = mant_i[1] | mant_i[0];
`endif
            end
            SEL_LEFT:  mant_o = {mant_i[MANT_W-2:0], 1'b0};
            default:   mant_o = mant_i;
        endcase
    end

endmodule

// File: rtl/fp_normalizer_seq.sv
// Sequential mantissa normalizer: one 1-bit shift per clock with exponent tracking
// and zero/overflow/underflow flags. Sticky right shift enabled by FP_NORM_STICKY_EN.
module fp_normalizer_seq
    import fp_pkg::*;
#(
    parameter int MANT_W = 29,
    parameter int EXP_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] mant_in,
    input  logic [EXP_W-1:0]  exp_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] mant_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic              zero,
    output logic              ovf,
    output logic              unf
);

    localparam logic [EXP_W-1:0] EXP_MAX    = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_MAX_M1 = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EXP_W-1:0] EXP_ONE    = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_ZERO   = {EXP_W{1'b0}};

    norm_state_t       state_q;
    logic [MANT_W-1:0] mant_q;
    logic [EXP_W-1:0]  exp_q;
    logic [MANT_W-1:0] mant_out_q;
    logic [EXP_W-1:0]  exp_out_q;
    logic              zero_q;
    logic              ovf_q;
    logic              unf_q;

    logic [1:0]        sel;
    logic [MANT_W-1:0] mant_d;

    // The shifter output is only committed when the FSM decides to shift.
    always_comb begin
        sel = SEL_NONE;
        if (state_q == SHIFT) begin
            if (mant_q[MANT_W-1]) begin
                sel = SEL_RIGHT;
            end else if (!mant_q[MANT_W-2]) begin
                sel = SEL_LEFT;
            end
        end
    end

    fp_shift_step #(
        .MANT_W (MANT_W)
    ) u_shift_step (
        .sel_i  (sel),
        .mant_i (mant_q),
        .mant_o (mant_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            mant_out_q <= '0;
            exp_out_q  <= '0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mant_q  <= mant_in;
                        exp_q   <= exp_in;
                        zero_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (mant_q == '0) begin
                        zero_q     <= 1'b1;
                        mant_out_q <= '0;
                        exp_out_q  <= EXP_ZERO;
                        state_q    <= DONE;
                    end else if (exp_q == EXP_MAX) begin
                        // Inf/NaN exponent on input: pass through untouched.
                        ovf_q      <= 1'b1;
                        mant_out_q <= mant_q;
                        exp_out_q  <= exp_q;
                        state_q    <= DONE;
                    end else if (mant_q[MANT_W-1]) begin
                        if (exp_q == EXP_MAX_M1) begin
                            ovf_q      <= 1'b1;
                            mant_out_q <= mant_q;
                            exp_out_q  <= EXP_MAX;
                            state_q    <= DONE;
                        end else begin
                            mant_q <= mant_d;
                            exp_q  <= exp_q + EXP_ONE;
                        end
                    end else if (!mant_q[MANT_W-2]) begin
                        if (exp_q == EXP_ZERO) begin
                            unf_q      <= 1'b1;
                            mant_out_q <= mant_q;
                            exp_out_q  <= exp_q;
                            state_q    <= DONE;
                        end else begin
                            mant_q <= mant_d;
                            exp_q  <= exp_q - EXP_ONE;
                        end
                    end else begin
                        mant_out_q <= mant_q;
                        exp_out_q  <= exp_q;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign mant_out  = mant_out_q;
    assign exp_out   = exp_out_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_fp_normalizer_seq.sv
// Directed bench for fp_normalizer_seq (MANT_W=29, EXP_W=8); sticky expectations follow FP_NORM_STICKY_EN.
module tb_fp_normalizer_seq;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [28:0] mant_in;
    logic [7:0]  exp_in;
    logic        out_valid;
    logic        out_ready;
    logic [28:0] mant_out;
    logic [7:0]  exp_out;
    logic        zero;
    logic        ovf;
    logic        unf;

    int tests_run;
    int tests_failed;

    fp_normalizer_seq #(
        .MANT_W (29),
        .EXP_W  (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant_in   (mant_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mant_out  (mant_out),
        .exp_out   (exp_out),
        .zero      (zero),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stimulus only: presents one pair, then counts edges after the accept edge until out_valid.
    task automatic send(input logic [28:0] m, input logic [7:0] e, output int lat);
        @(negedge clock);
        in_valid = 1'b1;
        mant_in  = m;
        exp_in   = e;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_hs: got ready/valid %b expected 10", {in_ready, out_valid});
        end
        tests_run++;
        if ({mant_out, exp_out, zero, ovf, unf} !== 40'h0) begin
            tests_failed++;
            $display("FAIL reset_outs: got %h expected 0", {mant_out, exp_out, zero, ovf, unf});
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_right_shift();
        int lat;
        send(29'h1000_0000, 8'd10, lat);
        tests_run++;
        if (lat !== 2) begin
            tests_failed++;
            $display("FAIL right_lat: got %0d expected 2", lat);
        end
        tests_run++;
        if ({mant_out, exp_out, zero, ovf, unf} !== {29'h0800_0000, 8'd11, 3'b000}) begin
            tests_failed++;
            $display("FAIL right_res: got m=%h e=%0d z/o/u=%b expected m=08000000 e=11 z/o/u=000",
                     mant_out, exp_out, {zero, ovf, unf});
        end
        release_result();
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL right_release: got ready/valid %b expected 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_left_shift();
        int lat;
        send(29'h0000_0001, 8'd100, lat);
        tests_run++;
        if (lat !== 28) begin
            tests_failed++;
            $display("FAIL left_lat: got %0d expected 28", lat);
        end
        tests_run++;
        if ({mant_out, exp_out, zero, ovf, unf} !== {29'h0800_0000, 8'd73, 3'b000}) begin
            tests_failed++;
            $display("FAIL left_res: got m=%h e=%0d z/o/u=%b expected m=08000000 e=73 z/o/u=000",
                     mant_out, exp_out, {zero, ovf, unf});
        end
        release_result();
    endtask

    task automatic test_normalized();
        int lat;
        send(29'h0812_3456, 8'd77, lat);
        tests_run++;
        if (lat !== 1 || {mant_out, exp_out, zero, ovf, unf} !== {29'h0812_3456, 8'd77, 3'b000}) begin
            tests_failed++;
            $display("FAIL norm_passthru: got lat=%0d m=%h e=%0d z/o/u=%b expected lat=1 m=08123456 e=77 z/o/u=000",
                     lat, mant_out, exp_out, {zero, ovf, unf});
        end
        release_result();
    endtask

    task automatic test_zero();
        int lat;
        send(29'h0, 8'd50, lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL zero_lat: got %0d expected 1", lat);
        end
        tests_run++;
        if ({mant_out, exp_out, zero, ovf, unf} !== {29'h0, 8'd0, 3'b100}) begin
            tests_failed++;
            $display("FAIL zero_res: got m=%h e=%0d z/o/u=%b expected m=0 e=0 z/o/u=100",
                     mant_out, exp_out, {zero, ovf, unf});
        end
        release_result();
    endtask

    task automatic test_underflow();
        int lat;
        send(29'h0000_0100, 8'd5, lat);
        tests_run++;
        if (lat !== 6) begin
            tests_failed++;
            $display("FAIL unf_lat: got %0d expected 6", lat);
        end
        tests_run++;
        if ({mant_out, exp_out, zero, ovf, unf} !== {29'h0000_2000, 8'd0, 3'b001}) begin
            tests_failed++;
            $display("FAIL unf_res: got m=%h e=%0d z/o/u=%b expected m=00002000 e=0 z/o/u=001",
                     mant_out, exp_out, {zero, ovf, unf});
        end
        release_result();
    endtask

    task automatic test_overflow();
        int lat;
        send(29'h1000_0000, 8'd254, lat);
        tests_run++;
        if (lat !== 1 || {mant_out, exp_out, zero, ovf, unf} !== {29'h1000_0000, 8'd255, 3'b010}) begin
            tests_failed++;
            $display("FAIL ovf_res: got lat=%0d m=%h e=%0d z/o/u=%b expected lat=1 m=10000000 e=255 z/o/u=010",
                     lat, mant_out, exp_out, {zero, ovf, unf});
        end
        release_result();
        send(29'h0123_4567, 8'd255, lat);
        tests_run++;
        if (lat !== 1 || {mant_out, exp_out, zero, ovf, unf} !== {29'h0123_4567, 8'd255, 3'b010}) begin
            tests_failed++;
            $display("FAIL expmax_in: got lat=%0d m=%h e=%0d z/o/u=%b expected lat=1 m=01234567 e=255 z/o/u=010",
                     lat, mant_out, exp_out, {zero, ovf, unf});
        end
        release_result();
    endtask

    task automatic test_sticky();
        int lat;
        logic [28:0] exp_m;
`ifdef FP_NORM_STICKY_EN
        exp_m = 29'h0800_0001;
`else
        exp_m = 29'h0800_0000;
`endif
        send(29'h1000_0001, 8'd10, lat);
        tests_run++;
        if (lat !== 2 || {mant_out, exp_out, zero, ovf, unf} !== {exp_m, 8'd11, 3'b000}) begin
            tests_failed++;
            $display("FAIL sticky_res: got lat=%0d m=%h e=%0d expected lat=2 m=%h e=11",
                     lat, mant_out, exp_out, exp_m);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        send(29'h1000_0000, 8'd20, lat);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            mant_in  = 29'h0000_0003;
            exp_in   = 8'd9;
            @(posedge clock);
            #1;
            tests_run++;
            if ({out_valid, in_ready, mant_out, exp_out, zero, ovf, unf} !==
                {1'b1, 1'b0, 29'h0800_0000, 8'd21, 3'b000}) begin
                tests_failed++;
                $display("FAIL hold_%0d: got v=%b r=%b m=%h e=%0d expected v=1 r=0 m=08000000 e=21",
                         i, out_valid, in_ready, mant_out, exp_out);
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        send(29'h0, 8'd3, lat);
        release_result();
        @(negedge clock);
        in_valid = 1'b1;
        mant_in  = 29'h0400_0000;
        exp_in   = 8'd40;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        tests_run++;
        if ({in_ready, out_valid, zero, ovf, unf} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL b2b_flagclr: got r/v/z/o/u=%b expected 00000", {in_ready, out_valid, zero, ovf, unf});
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        tests_run++;
        if (lat !== 2 || {mant_out, exp_out, zero, ovf, unf} !== {29'h0800_0000, 8'd39, 3'b000}) begin
            tests_failed++;
            $display("FAIL b2b_res: got lat=%0d m=%h e=%0d expected lat=2 m=08000000 e=39",
                     lat, mant_out, exp_out);
        end
        release_result();
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clock);
        in_valid = 1'b1;
        mant_in  = 29'h0000_0001;
        exp_in   = 8'd100;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        tests_run++;
        if ({in_ready, out_valid, mant_out, exp_out, zero, ovf, unf} !== {2'b10, 29'h0, 8'd0, 3'b000}) begin
            tests_failed++;
            $display("FAIL midreset_state: got r=%b v=%b m=%h e=%0d expected r=1 v=0 m=0 e=0",
                     in_ready, out_valid, mant_out, exp_out);
        end
        repeat (35) @(posedge clock);
        #1;
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL midreset_nooutput: got ready/valid %b expected 10", {in_ready, out_valid});
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mant_in   = '0;
        exp_in    = '0;
        test_reset();
        test_right_shift();
        test_left_shift();
        test_normalized();
        test_zero();
        test_underflow();
        test_overflow();
        test_sticky();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
